// File: rtl/alu_issue_wb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_issue_wb                                                 |
// | Description : Single-issue front end for an external combinational ALU:    |
// |               16x16 register file, 5-bit PSR, IDLE/EXEC/WB sequencer.      |
// |               Define REGFILE_ZERO_REG_EN to hard-wire R0 to zero.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_issue_wb (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [7:0]  alu_opcode,
    output logic        alu_cin,
    input  logic [15:0] alu_c,
    input  logic [4:0]  alu_flags,
    output logic        wb_done,
    output logic [4:0]  psr,
    input  logic [3:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EXEC = 2'd1;
    localparam logic [1:0] c_WB   = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [15:0] r_rf [16];
    logic [15:0] r_alu_a;
    logic [15:0] r_alu_b;
    logic [15:0] r_res;
    logic [7:0]  r_opcode;
    logic        r_cin;
    logic [3:0]  r_rdest;
    logic [4:0]  r_psr;
    logic [4:0]  r_flags;
    logic        w_accept;
    logic        w_op_writes;
    logic        w_rf_we;
    logic        w_psr_we;
    logic [15:0] w_rd_a;
    logic [15:0] w_rd_b;

    assign w_accept = (r_state == c_IDLE) && instr_valid;

    // Compares and NOP only affect flags (or nothing); everything else writes Rdest.
    assign w_op_writes = !((r_opcode == 8'h00) || (r_opcode == 8'h0B) ||
                           (r_opcode == 8'h0C) || (r_opcode[7:4] == 4'hB) ||
                           (r_opcode[7:4] == 4'hC));
    assign w_psr_we    = (r_state == c_WB) && (r_opcode != 8'h00);

`ifdef REGFILE_ZERO_REG_EN
    assign w_rd_a   = (instr[11:8] == 4'd0) ? 16'h0000 : r_rf[instr[11:8]];
    assign w_rd_b   = (instr[3:0]  == 4'd0) ? 16'h0000 : r_rf[instr[3:0]];
    assign dbg_data = (dbg_addr    == 4'd0) ? 16'h0000 : r_rf[dbg_addr];
    assign w_rf_we  = (r_state == c_WB) && w_op_writes && (r_rdest != 4'd0);
`else
    assign w_rd_a   = r_rf[instr[11:8]];
    assign w_rd_b   = r_rf[instr[3:0]];
    assign dbg_data = r_rf[dbg_addr];
    assign w_rf_we  = (r_state == c_WB) && w_op_writes;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_accept) w_state_nxt = c_EXEC;
            c_EXEC:  w_state_nxt = c_WB;
            c_WB:    w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Operands are captured at accept and held so the ALU sees stable inputs for EXEC and WB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alu_a  <= 16'h0000;
            r_alu_b  <= 16'h0000;
            r_opcode <= 8'h00;
            r_cin    <= 1'b0;
            r_rdest  <= 4'd0;
            r_res    <= 16'h0000;
            r_flags  <= 5'b00000;
            r_psr    <= 5'b00000;
        end else begin
            if (w_accept) begin
                r_alu_a  <= w_rd_a;
                r_alu_b  <= w_rd_b;
                r_opcode <= {instr[15:12], instr[7:4]};
                r_cin    <= r_psr[3];
                r_rdest  <= instr[11:8];
            end
            if (r_state == c_EXEC) begin
                r_res   <= alu_c;
                r_flags <= alu_flags;
            end
            if (w_psr_we) begin
                r_psr <= r_flags;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                r_rf[i] <= 16'h0000;
            end
        end else if (w_rf_we) begin
            r_rf[r_rdest] <= r_res;
        end
    end

    assign instr_ready = (r_state == c_IDLE);
    assign wb_done     = (r_state == c_WB);
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_opcode  = r_opcode;
    assign alu_cin     = r_cin;
    assign psr         = r_psr;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_wb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_issue_wb                                              |
// | Description : Bench for alu_issue_wb with a behavioural ALU and register   |
// |               model; honours REGFILE_ZERO_REG_EN like the design.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_alu_issue_wb;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic        instr_ready;
    logic [15:0] alu_a, alu_b, alu_c;
    logic [7:0]  alu_opcode;
    logic        alu_cin;
    logic [4:0]  alu_flags;
    logic        wb_done;
    logic [4:0]  psr;
    logic [3:0]  dbg_addr = 4'd0;
    logic [15:0] dbg_data;

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0] mreg [16];
    logic [4:0]  mpsr;

    alu_issue_wb dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .alu_a(alu_a), .alu_b(alu_b),
        .alu_opcode(alu_opcode), .alu_cin(alu_cin), .alu_c(alu_c),
        .alu_flags(alu_flags), .wb_done(wb_done), .psr(psr),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // Result word is {Z,C,F,N,L, result[15:0]}.
    function automatic logic [20:0] add_f(input logic [15:0] a, input logic [15:0] b, input logic c);
        logic [16:0] s = {1'b0, a} + {1'b0, b} + {16'h0000, c};
        logic [15:0] r = s[15:0];
        return {r == 16'h0000, s[16], (a[15] == b[15]) && (r[15] != a[15]), 2'b00, r};
    endfunction

    function automatic logic [20:0] cmp_f(input logic [15:0] a, input logic [15:0] b);
        return {a == b, 2'b00, $signed(a) < $signed(b), a < b, 16'h0000};
    endfunction

    function automatic logic [20:0] alu_fn(input logic [7:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic cin);
        logic [15:0] imm = {12'h000, op[3:0]};
        logic [15:0] r;
        case (op[7:4])
            4'h5, 4'h6: return add_f(a, imm, 1'b0);
            4'hB, 4'hC: return cmp_f(a, imm);
            4'h0: begin
                case (op[3:0])
                    4'h1: begin r = a & b; return {r == 16'h0000, 4'b0000, r}; end
                    4'h2: begin r = a | b; return {r == 16'h0000, 4'b0000, r}; end
                    4'h3: begin r = a ^ b; return {r == 16'h0000, 4'b0000, r}; end
                    4'h5, 4'h6: return add_f(a, b, 1'b0);
                    4'h7: return add_f(a, b, cin);
                    4'h9: begin
                        r = a - b;
                        return {r == 16'h0000, a < b, (a[15] != b[15]) && (r[15] != a[15]), 2'b00, r};
                    end
                    4'hB, 4'hC: return cmp_f(a, b);
                    default: return 21'h0;
                endcase
            end
            default: return 21'h0;
        endcase
    endfunction

    assign {alu_flags, alu_c} = alu_fn(alu_opcode, alu_a, alu_b, alu_cin);

    function automatic logic [15:0] mread(input logic [3:0] a);
`ifdef REGFILE_ZERO_REG_EN
        if (a == 4'd0) return 16'h0000;
`endif
        return mreg[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mreg[i] = 16'h0000;
        mpsr = 5'b00000;
    endtask

    // Retire one instruction in the architectural model.
    task automatic model_exec(input logic [15:0] ins);
        logic [7:0]  op = {ins[15:12], ins[7:4]};
        logic [20:0] o  = alu_fn(op, mread(ins[11:8]), mread(ins[3:0]), mpsr[3]);
        logic        wr = !(op inside {8'h00, 8'h0B, 8'h0C}) && !(op[7:4] inside {4'hB, 4'hC});
        if (wr) mreg[ins[11:8]] = o[15:0];
        if (op != 8'h00) mpsr = o[20:16];
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Drive one instruction through accept/EXEC/WB, checking the handshake and operands.
    task automatic issue(input logic [15:0] ins);
        logic [15:0] ea = mread(ins[11:8]);
        logic [15:0] eb = mread(ins[3:0]);
        logic        ec = mpsr[3];
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = ins;
        for (int w = 0; w < 8 && !instr_ready; w++) @(negedge clk);
        chk("issue_ready", instr_ready, 1);
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = 16'($urandom);
        chk("exec_ready", instr_ready, 0);
        chk("exec_wb_done", wb_done, 0);
        chk("exec_alu_a", alu_a, ea);
        chk("exec_alu_b", alu_b, eb);
        chk("exec_opcode", alu_opcode, {ins[15:12], ins[7:4]});
        chk("exec_cin", alu_cin, ec);
        @(negedge clk);
        chk("wb_done", wb_done, 1);
        chk("wb_alu_a", alu_a, ea);
        model_exec(ins);
        @(negedge clk);
        chk("post_wb_done", wb_done, 0);
        chk("post_ready", instr_ready, 1);
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] r = 16'($urandom);
        logic [7:0]  op;
        case ($urandom_range(0, 15))
            0:  op = 8'h01;
            1:  op = 8'h02;
            2:  op = 8'h03;
            3:  op = 8'h05;
            4:  op = 8'h06;
            5:  op = 8'h07;
            6:  op = 8'h09;
            7:  op = 8'h0B;
            8:  op = 8'h0C;
            9:  op = {4'h6, r[7:4]};
            10: op = {4'h5, r[7:4]};
            11: op = {4'hB, r[7:4]};
            12: op = {4'hC, r[7:4]};
            13: op = 8'h00;
            default: op = {r[15:12], r[7:4]};
        endcase
        return {op[7:4], r[11:8], op[3:0], r[3:0]};
    endfunction

    task automatic abort_test(input int extra);
        @(negedge clk);
        instr       = 16'h6590;
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (extra) @(negedge clk);
        chk("abort_phase_wb_done", wb_done, extra);
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        model_reset();
        chk("abort_ready", instr_ready, 1);
        chk("abort_wb_done", wb_done, 0);
        repeat (3) @(negedge clk);
        dbg_addr = 4'd5;
        #1;
        chk("abort_r5", dbg_data, 16'h0000);
        chk("abort_psr", psr, 5'b00000);
        chk("abort_idle", instr_ready, 1);
    endtask

    typedef struct {
        logic [15:0] ins;
        logic [3:0]  addr;
        logic [15:0] val;
        logic [4:0]  psr;
    } vec_t;

    vec_t tbl [15];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc [$];
        model_reset();

        tbl[0]  = '{16'h6130, 4'd1, 16'h0003, 5'h00};  // ADDUI R1,#3
        tbl[1]  = '{16'h6240, 4'd2, 16'h0004, 5'h00};  // ADDUI R2,#4
        tbl[2]  = '{16'h0152, 4'd1, 16'h0007, 5'h00};  // ADD R1,R2
        tbl[3]  = '{16'h02B1, 4'd2, 16'h0004, 5'h03};  // CMP R2,R1 (4<7)
        tbl[4]  = '{16'h6310, 4'd3, 16'h0001, 5'h00};  // ADDUI R3,#1
        tbl[5]  = '{16'h0693, 4'd6, 16'hFFFF, 5'h08};  // SUB R6,R3 (borrow)
        tbl[6]  = '{16'h0663, 4'd6, 16'h0000, 5'h18};  // ADDU R6,R3 wraps
        tbl[7]  = '{16'h0770, 4'd7, 16'h0001, 5'h00};  // ADDCU R7,R0 with carry
        tbl[8]  = '{16'h6850, 4'd8, 16'h0005, 5'h00};  // ADDUI R8,#5
        tbl[9]  = '{16'h6950, 4'd9, 16'h0005, 5'h00};  // ADDUI R9,#5
        tbl[10] = '{16'h08B9, 4'd8, 16'h0005, 5'h10};  // CMP R8,R9 equal
        tbl[11] = '{16'hB870, 4'd8, 16'h0005, 5'h03};  // CMPI R8,#7
        tbl[12] = '{16'h0100, 4'd1, 16'h0007, 5'h03};  // NOP
        tbl[13] = '{16'hF900, 4'd9, 16'h0000, 5'h00};  // undefined opcode
`ifdef REGFILE_ZERO_REG_EN
        tbl[14] = '{16'h6090, 4'd0, 16'h0000, 5'h00};  // ADDUI R0,#9
`else
        tbl[14] = '{16'h6090, 4'd0, 16'h0009, 5'h00};
`endif

        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        for (int a = 0; a < 16; a++) begin
            dbg_addr = 4'(a);
            #1;
            chk("reset_reg", dbg_data, 16'h0000);
        end
        chk("reset_psr", psr, 5'b00000);
        chk("reset_ready", instr_ready, 1);
        chk("reset_wb_done", wb_done, 0);
        chk("reset_alu_a", alu_a, 16'h0000);
        chk("reset_opcode", alu_opcode, 8'h00);
        chk("reset_cin", alu_cin, 0);

        for (int i = 0; i < 15; i++) begin
            issue(tbl[i].ins);
            dbg_addr = tbl[i].addr;
            #1;
            chk("tbl_reg", dbg_data, tbl[i].val);
            chk("tbl_psr", psr, tbl[i].psr);
        end

        // Held-valid stream: one accept per IDLE visit.
        @(negedge clk);
        instr       = 16'h6410;
        instr_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (instr_ready) begin
                acc.push_back(k);
                model_exec(16'h6410);
            end
            @(negedge clk);
        end
        instr_valid = 1'b0;
        chk("b2b_count", acc.size(), 4);
        for (int j = 1; j < acc.size(); j++) chk("b2b_gap", acc[j] - acc[j-1], 3);
        dbg_addr = 4'd4;
        #1;
        chk("b2b_r4", dbg_data, 16'h0004);
        chk("b2b_model_r4", dbg_data, mread(4'd4));

        for (int n = 0; n < 60; n++) begin
            logic [15:0] ri = rand_instr();
            issue(ri);
            dbg_addr = ri[11:8];
            #1;
            chk("rand_reg", dbg_data, mread(ri[11:8]));
            chk("rand_psr", psr, mpsr);
        end
        for (int a = 0; a < 16; a++) begin
            dbg_addr = 4'(a);
            #1;
            chk("rand_sweep", dbg_data, mread(4'(a)));
        end

        abort_test(0);
        abort_test(1);

        // First accept right after reset, then the zero-register case.
        issue(16'h6090);
        dbg_addr = 4'd0;
        #1;
        chk("r0_after_reset", dbg_data, mread(4'd0));
        issue(16'h0000);
        chk("r0_nop_psr", psr, 5'b00000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_issue_wb.md
ALU_ISSUE_WB -- requirements
Module: alu_issue_wb

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 instr_valid  input  1  instruction word offered.
REQ-004 instr  input  16  instruction: [15:12] op-hi, [11:8] Rdest, [7:4] op-lo/imm, [3:0] Rsrc.
REQ-005 instr_ready  output  1  block can accept an instruction.
REQ-006 alu_a, alu_b  output  16 each  operands to the ALU.
REQ-007 alu_opcode  output  8  ALU opcode = {instr[15:12], instr[7:4]}.
REQ-008 alu_cin  output  1  carry-in to the ALU = PSR carry bit.
REQ-009 alu_c  input  16  ALU result.
REQ-010 alu_flags  input  5  ALU flags {Z,C,F,N,L} = bits [4:0].
REQ-011 wb_done  output  1  one-cycle pulse when an instruction retires.
REQ-012 psr  output  5  program status register contents.
REQ-013 dbg_addr  input  4 / dbg_data  output  16  combinational debug read of register dbg_addr.

Function
REQ-014 Storage: 16 x 16-bit register file R0..R15 plus 5-bit PSR.
REQ-015 FSM states IDLE, EXEC, WB; IDLE->EXEC on instr_valid&instr_ready; EXEC->WB unconditionally; WB->IDLE unconditionally.
REQ-016 instr_ready SHALL be 1 only in IDLE; instr ignored in other states.
REQ-017 On accept, instr SHALL be latched; alu_a<=R[Rdest], alu_b<=R[Rsrc], alu_opcode, alu_cin<=psr[3] are registered and held stable through EXEC and WB.
REQ-018 alu_c and alu_flags SHALL be sampled at the end of EXEC (one full cycle of combinational ALU settle).
REQ-019 At the end of WB, R[Rdest] SHALL be written with the sampled result unless opcode is NOP 8'h00, CMP 8'h0B, CMPU 8'h0C, or op-hi 4'hB (CMPI) or 4'hC (CMPUI).
REQ-020 At the end of WB, psr SHALL be written with the sampled flags for every opcode except NOP; undefined opcodes write result 0 and flags 0 as the ALU returns them.
REQ-021 wb_done SHALL be 1 exactly during the WB cycle.
REQ-022 Latency: accept at edge T -> register/PSR update visible after edge T+2; next accept possible at edge T+3; peak throughput one instruction per 3 cycles.
REQ-023 Rdest==Rsrc SHALL read the same value on both operands; no hazard exists because issue stalls until WB completes.
REQ-024 dbg_data SHALL reflect the written value from the cycle after the WB edge.
REQ-025 instr_valid held high continuously SHALL be accepted once per IDLE visit only.

Reset
REQ-026 Reset asserted: state=IDLE, all registers R0..R15=16'h0000, psr=5'b00000, alu_a/alu_b=0, alu_opcode=8'h00, alu_cin=0, wb_done=0, instr_ready=1.
REQ-027 Reset during EXEC or WB SHALL abort the instruction with no register or PSR write.
REQ-028 After reset deassertion, first accept is possible at the first rising edge.

Configuration
REQ-029 Macro REGFILE_ZERO_REG_EN defined: R0 reads 16'h0000 always and writes to R0 are discarded (PSR still updated).
REQ-030 Macro REGFILE_ZERO_REG_EN undefined: R0 is an ordinary writable register.

Verification
REQ-031 Reset, then dbg_addr sweep 0..15 -> every dbg_data=16'h0000, psr=0, instr_ready=1.
REQ-032 R1=16'h0003, R2=16'h0004 (via ADDUI), issue ADD R1,R2 (instr 16'h0152) -> R1=16'h0007, psr=0, wb_done pulses 2 cycles after accept.
REQ-033 R1=16'hFFFF, R2=16'h0001, ADDU R1,R2 then ADDCU R3,R0 with R3=0 -> R1=0, psr[4]=1, psr[3]=1; then alu_cin=1 and R3=16'h0001.
REQ-034 R1=16'h0005, R2=16'h0005, CMP R1,R2 (16'h01B2) -> R1 unchanged 16'h0005, psr=5'b10000.
REQ-035 instr_valid held high with back-to-back ADDUI R4,#1 -> accepts spaced exactly 3 cycles, R4 increments by 1 per retire.
REQ-036 Reset pulsed during EXEC of ADDUI R5,#9 -> R5 stays 0, psr 0, state IDLE; with REGFILE_ZERO_REG_EN, ADDUI R0,#9 -> R0 reads 0.
